// File: rtl/saturn_serial_pkg.sv
`default_nettype none
// saturn_serial_pkg: shared FSM encoding and counter widths for the debug serial TX.
// Revision 1.0
package saturn_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned c_default_clks_per_bit = 104;
  localparam int unsigned c_baud_cnt_w           = 16;
  localparam int unsigned c_sent_cnt_w           = 10;
  localparam int unsigned c_bit_idx_w            = 3;

endpackage
`default_nettype wire

// File: rtl/saturn_serial_fifo.sv
`default_nettype none
// saturn_serial_fifo: single-clock character FIFO with a separate level counter.
// Revision 1.0
module saturn_serial_fifo
  import saturn_serial_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [7:0]             i_wdata,
  input  logic                   i_pop,
  output logic [7:0]             o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [FIFO_ADDR_W:0]   o_level
);

  localparam int unsigned c_depth = 2 ** FIFO_ADDR_W;

  logic [7:0]             mem_q [c_depth];
  logic [FIFO_ADDR_W-1:0] wr_ptr_q;
  logic [FIFO_ADDR_W-1:0] rd_ptr_q;
  logic [FIFO_ADDR_W:0]   level_q;
  logic                   w_push_ok;
  logic                   w_pop_ok;

  // Full/empty come from the registered level, so a push on the same edge
  // as a pop from a full FIFO is still refused.
  assign o_full    = (level_q == (FIFO_ADDR_W + 1)'(c_depth));
  assign o_empty   = (level_q == '0);
  assign o_level   = level_q;
  assign o_rdata   = mem_q[rd_ptr_q];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/saturn_serial_tx.sv
`default_nettype none
// saturn_serial_tx: buffers bus-controller debug characters and sends them as 8N1 UART frames.
// Revision 1.0
module saturn_serial_tx
  import saturn_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_default_clks_per_bit,
  parameter int unsigned FIFO_ADDR_W  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [7:0]                i_char_to_send,
  input  logic                      i_char_valid,
  input  logic                      i_char_send,
  output logic                      o_serial_busy,
  output logic                      o_tx,
  output logic [FIFO_ADDR_W:0]      o_fifo_level,
  output logic [c_sent_cnt_w-1:0]   o_sent_counter,
  output logic                      o_overflow
);

  localparam logic [c_baud_cnt_w-1:0] c_baud_last = c_baud_cnt_w'(CLKS_PER_BIT - 1);

  tx_state_e               state_q;
  logic                    tx_q;
  logic [7:0]              shift_q;
  logic [c_bit_idx_w-1:0]  bit_idx_q;
  logic [c_baud_cnt_w-1:0] baud_q;
  logic [c_sent_cnt_w-1:0] sent_q;
  logic                    overflow_q;

  logic                    w_strobe;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic [7:0]              w_head;

  assign w_strobe = i_char_send && i_char_valid;
  assign w_pop    = (state_q == ST_IDLE) && !w_empty;

  saturn_serial_fifo #(
    .FIFO_ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_strobe),
    .i_wdata (i_char_to_send),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  // o_tx is driven from the state of the previous cycle, which gives the
  // one-cycle pop-to-start latency and the single idle-high gap between frames.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      sent_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_strobe && w_full) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!w_empty) begin
            shift_q   <= w_head;
            bit_idx_q <= '0;
            baud_q    <= '0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          tx_q <= 1'b0;
          if (baud_q == c_baud_last) begin
            baud_q  <= '0;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_DATA: begin
          tx_q <= shift_q[0];
          if (baud_q == c_baud_last) begin
            baud_q    <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (baud_q == c_baud_last) begin
            baud_q  <= '0;
            sent_q  <= sent_q + 1'b1;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx           = tx_q;
  assign o_serial_busy  = w_full;
  assign o_sent_counter = sent_q;
  assign o_overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_saturn_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// tb_saturn_serial_tx: scoreboard bench; a UART line monitor decodes frames and checks them.
// Revision 1.0
module tb_saturn_serial_tx;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    d = 8'h00;
  logic          valid = 1'b0;
  logic          send = 1'b0;
  logic          busy;
  logic          tx;
  logic [AW:0]   level;
  logic [9:0]    sent;
  logic          ovf;

  typedef struct {
    logic [7:0] data;
    int         level;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_in_frame = 1'b0;
  int   mon_sample = 0;
  int   frame_starts = 0;

  saturn_serial_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_ADDR_W  (AW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_char_to_send (d),
    .i_char_valid   (valid),
    .i_char_send    (send),
    .o_serial_busy  (busy),
    .o_tx           (tx),
    .o_fifo_level   (level),
    .o_sent_counter (sent),
    .o_overflow     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] dd, input int lv, input int gp);
    exp_t e;
    e.data  = dd;
    e.level = lv;
    e.gap   = gp;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Line monitor: a frame is 10*CPB samples; every sample of a bit must agree.
  initial begin : monitor
    int         idle_cnt;
    int         gap;
    int         lvl;
    logic [9:0] bits;
    bit         shape_err;
    exp_t       e;
    idle_cnt  = 0;
    gap       = 0;
    lvl       = 0;
    bits      = '0;
    shape_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_in_frame = 1'b0;
        idle_cnt     = 0;
      end else if (!mon_in_frame && tx === 1'b1) begin
        idle_cnt++;
      end else begin
        if (!mon_in_frame) begin
          mon_in_frame = 1'b1;
          mon_sample   = 0;
          gap          = idle_cnt;
          idle_cnt     = 0;
          lvl          = int'(level);
          shape_err    = 1'b0;
          bits         = '0;
          frame_starts++;
        end
        if (mon_sample % CPB == 0) bits[mon_sample / CPB] = tx;
        else if (tx !== bits[mon_sample / CPB]) shape_err = 1'b1;
        mon_sample++;
        if (mon_sample == 10 * CPB) begin
          mon_in_frame = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected got=%02h", bits[8:1]);
          end else begin
            e = sb.pop_front();
            if (bits[8:1] !== e.data || bits[0] !== 1'b0 || bits[9] !== 1'b1 || shape_err ||
                (e.level >= 0 && lvl != e.level) || (e.gap >= 0 && gap != e.gap)) begin
              errors++;
              $display("FAIL frame got data=%02h start=%b stop=%b shape_err=%0d level=%0d gap=%0d expected data=%02h level=%0d gap=%0d",
                       bits[8:1], bits[0], bits[9], shape_err, lvl, gap, e.data, e.level, e.gap);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] t2_data [3];
    int         t2_lvl  [3];
    int         t2_gap  [3];
    int         starts;
    int         n;
    bit         stall;

    t2_data = '{8'h00, 8'hFF, 8'h55};
    t2_lvl  = '{2, 1, 0};
    t2_gap  = '{-1, 1, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tx",    32'(tx),    32'd1);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_sent",  32'(sent),  32'd0);
    check("reset_ovf",   32'(ovf),   32'd0);

    // Single 0x41 frame and start latency
    push_exp(8'h41, 0, -1);
    @(posedge clk); #1;
    d = 8'h41; valid = 1'b1; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0; valid = 1'b0;
    check("t1_level_after_accept", 32'(level), 32'd1);
    check("t1_tx_after_E0", 32'(tx), 32'd1);
    @(posedge clk); #1;
    check("t1_tx_after_E1", 32'(tx), 32'd1);
    @(posedge clk); #1;
    check("t1_tx_after_E2", 32'(tx), 32'd0);
    wait_drain("t1_drain", 200);
    check("t1_sent", 32'(sent), 32'd1);

    // Three back-to-back bytes
    @(posedge clk); #1;
    valid = 1'b1; send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = t2_data[i];
      push_exp(t2_data[i], t2_lvl[i], t2_gap[i]);
      @(posedge clk); #1;
    end
    send = 1'b0; valid = 1'b0;
    check("t2_level_after_writes", 32'(level), 32'd2);
    wait_drain("t2_drain", 400);
    check("t2_sent", 32'(sent), 32'd4);
    check("t2_level_end", 32'(level), 32'd0);

    // Strobe without valid is ignored
    starts = frame_starts;
    @(posedge clk); #1;
    d = 8'hAA; valid = 1'b0; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    check("inv_level_now", 32'(level), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("inv_level", 32'(level), 32'd0);
    check("inv_no_frame", 32'(frame_starts), 32'(starts));
    check("inv_ovf", 32'(ovf), 32'd0);

    // 18 strobes with no gaps: 17 accepted (one pops at E1), the 18th dropped
    @(posedge clk); #1;
    valid = 1'b1; send = 1'b1;
    for (int i = 0; i < 18; i++) begin
      d = 8'(8'h80 + i);
      if (i < 17) push_exp(8'(8'h80 + i), -1, (i == 0) ? -1 : 1);
      @(posedge clk); #1;
      if (i == 16) begin
        check("ovf_level_full", 32'(level), 32'd16);
        check("ovf_busy",       32'(busy),  32'd1);
        check("ovf_not_yet",    32'(ovf),   32'd0);
      end
      if (i == 17) begin
        check("ovf_set",        32'(ovf),   32'd1);
        check("ovf_level_hold", 32'(level), 32'd16);
      end
    end
    send = 1'b0; valid = 1'b0;
    wait_drain("ovf_drain", 2000);
    check("ovf_sent",   32'(sent), 32'd21);
    check("ovf_sticky", 32'(ovf),  32'd1);
    check("ovf_busy_clear", 32'(busy), 32'd0);

    // Reset in the middle of data bit 3 with more bytes queued
    @(posedge clk); #1;
    valid = 1'b1; send = 1'b1;
    d = 8'h12; @(posedge clk); #1;
    d = 8'h34; @(posedge clk); #1;
    d = 8'h56; @(posedge clk); #1;
    send = 1'b0; valid = 1'b0;
    n = 0;
    while (!(mon_in_frame && mon_sample == 4 * CPB + 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_bit3", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_tx",    32'(tx),    32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_sent",  32'(sent),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    starts = frame_starts;
    repeat (100) @(posedge clk);
    #1;
    check("rst_no_frame", 32'(frame_starts), 32'(starts));
    check("rst_tx_idle",  32'(tx), 32'd1);

    // 1024 frames wrap the sent counter
    stall = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      n = 0;
      while (busy && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) stall = 1'b1;
      d = 8'(i);
      push_exp(8'(i), -1, -1);
      valid = 1'b1; send = 1'b1;
      @(posedge clk); #1;
      send = 1'b0; valid = 1'b0;
    end
    check("wrap_no_stall", 32'(stall), 32'd0);
    wait_drain("wrap_drain", 2000);
    check("wrap_sent", 32'(sent), 32'd0);
    check("wrap_ovf",  32'(ovf),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
